// File: rtl/hrm_host_bridge.sv
// Host-side bridge for the HRM-CPU byte interface.
//   - RX stream -> circular buffer -> CPU INBOX writes
//   - CPU OUTBOX -> TX ready/valid stream
//   - On request, walks the CPU dump port and streams a snapshot frame:
//     MARK, PC, R, IR, STATE, N_in, INBOX[0..N_in-1], N_out, OUTBOX[0..N_out-1]
// Optional build macro HOST_BRIDGE_DUMP_CSUM_EN appends a modulo-256 sum of
// every frame byte after the mark (counts included).
// Handshake: a TX byte transfers on a rising clk edge where o_tx_valid and
// i_tx_ready are both high; o_tx_data is held stable while o_tx_valid waits.
// The FSM state is the internal signal 'state' (typedef state_t).
module hrm_host_bridge #(
    parameter int          RX_DEPTH  = 4,
    parameter logic [7:0]  DUMP_MARK = 8'hFF
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_cpu_in_data,
    output logic       o_cpu_in_wr,
    input  logic       i_cpu_in_full,
    input  logic [7:0] i_cpu_out_data,
    input  logic       i_cpu_out_empty,
    output logic       o_cpu_out_rd,
    output logic [2:0] o_dmp_chip_select,
    output logic [4:0] o_dmp_fifo_pos,
    input  logic [7:0] i_dmp_data,
    input  logic       i_dmp_valid,
    input  logic       i_dump_req,
    output logic       o_dump_busy,
    output logic       o_rx_drop
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Dump port selects; INBOX and OUTBOX are the CPU's two FIFOs.
    localparam logic [2:0] SEL_IN  = 3'd0;
    localparam logic [2:0] SEL_OUT = 3'd1;
    localparam logic [2:0] SEL_PC  = 3'd2;
    localparam logic [2:0] SEL_R   = 3'd4;
    localparam logic [2:0] SEL_IR  = 3'd5;
    localparam logic [2:0] SEL_ST  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_ORD, S_OSEND, S_OGAP, S_DADDR, S_DSAMP, S_DSEND, S_DCNT
    } state_t;

    // Which part of the dump frame the FSM is currently producing.
    typedef enum logic [2:0] {
        P_MARK, P_REG, P_CNT_IN, P_DAT_IN, P_CNT_OUT, P_DAT_OUT, P_CSUM
    } phase_t;

    state_t     state, state_n;
    phase_t     phase, phase_n;
    logic [5:0] idx, idx_n;
    logic [5:0] cnt, cnt_n;
    logic [7:0] tx_n;
    logic [2:0] sel_n;
    logic [4:0] pos_n;
    logic       dump_pend;
    logic       dump_done;
    logic       frame_end;
`ifdef HOST_BRIDGE_DUMP_CSUM_EN
    logic [7:0] csum;
    logic       dump_start;
    logic       tx_accept;
`endif

    // ---------------- RX buffer ----------------
    logic [7:0]  rx_mem [RX_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        rx_empty, rx_full, rx_push, rx_pop;

    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_pop   = !rx_empty && !i_cpu_in_full && !o_dump_busy;
    assign rx_push  = i_rx_valid && (!rx_full || rx_pop);

    // RX storage: written on every accepted host byte.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[wr_ptr[AW-1:0]] <= i_rx_data;
    end

    // RX pointers, registered INBOX write strobe and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_cpu_in_wr   <= 1'b0;
            o_cpu_in_data <= 8'h00;
            o_rx_drop     <= 1'b0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (rx_pop) begin
                rd_ptr        <= rd_ptr + PTR_ONE;
                o_cpu_in_data <= rx_mem[rd_ptr[AW-1:0]];
            end
            o_cpu_in_wr <= rx_pop;
            if (i_rx_valid && !rx_push) o_rx_drop <= 1'b1;
        end
    end

    // ---------------- TX / dump FSM ----------------
    assign o_cpu_out_rd = (state == S_ORD);
    assign o_tx_valid   = (state == S_OSEND) || (state == S_DSEND);
    assign o_dump_busy  = (state == S_DADDR) || (state == S_DSAMP) ||
                          (state == S_DSEND) || (state == S_DCNT);

    function automatic logic [2:0] reg_sel(input logic [1:0] i);
        case (i)
            2'd0:    return SEL_PC;
            2'd1:    return SEL_R;
            2'd2:    return SEL_IR;
            default: return SEL_ST;
        endcase
    endfunction

    // Pending snapshot request; requests that arrive mid-dump are ignored.
    always_ff @(posedge clk) begin
        if (!i_rst_n)                       dump_pend <= 1'b0;
        else if (dump_done)                 dump_pend <= 1'b0;
        else if (i_dump_req && !o_dump_busy) dump_pend <= 1'b1;
    end

`ifdef HOST_BRIDGE_DUMP_CSUM_EN
    // Running sum of frame bytes after the mark, excluding the sum itself.
    always_ff @(posedge clk) begin
        if (!i_rst_n || dump_start) csum <= 8'h00;
        else if (tx_accept && phase != P_MARK && phase != P_CSUM) csum <= csum + o_tx_data;
    end
`endif

    // State register plus the dump walker's datapath registers.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state             <= S_IDLE;
            phase             <= P_MARK;
            idx               <= '0;
            cnt               <= '0;
            o_tx_data         <= 8'h00;
            o_dmp_chip_select <= SEL_PC;
            o_dmp_fifo_pos    <= 5'd0;
        end else begin
            state             <= state_n;
            phase             <= phase_n;
            idx               <= idx_n;
            cnt               <= cnt_n;
            o_tx_data         <= tx_n;
            o_dmp_chip_select <= sel_n;
            o_dmp_fifo_pos    <= pos_n;
        end
    end

    // Next-state and next-datapath logic for OUTBOX drain and dump walk.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        idx_n     = idx;
        cnt_n     = cnt;
        tx_n      = o_tx_data;
        sel_n     = o_dmp_chip_select;
        pos_n     = o_dmp_fifo_pos;
        dump_done = 1'b0;
        frame_end = 1'b0;
`ifdef HOST_BRIDGE_DUMP_CSUM_EN
        dump_start = 1'b0;
        tx_accept  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (dump_pend) begin
                    state_n = S_DADDR;
                    phase_n = P_MARK;
                    idx_n   = 6'd0;
`ifdef HOST_BRIDGE_DUMP_CSUM_EN
                    dump_start = 1'b1;
`endif
                end else if (!i_cpu_out_empty) begin
                    state_n = S_ORD;
                end
            end
            S_ORD: begin
                tx_n    = i_cpu_out_data;
                state_n = S_OSEND;
            end
            S_OSEND: if (i_tx_ready) state_n = S_OGAP;
            S_OGAP:  state_n = S_IDLE;
            S_DADDR: begin
                pos_n = 5'd0;
                case (phase)
                    P_REG:                sel_n = reg_sel(idx[1:0]);
                    P_CNT_IN, P_DAT_IN:   sel_n = SEL_IN;
                    P_CNT_OUT, P_DAT_OUT: sel_n = SEL_OUT;
                    default:              sel_n = o_dmp_chip_select;
                endcase
                if (phase == P_DAT_IN || phase == P_DAT_OUT) pos_n = idx[4:0];
                if (phase == P_CNT_IN || phase == P_CNT_OUT) begin
                    cnt_n   = 6'd0;
                    state_n = S_DCNT;
                end else begin
                    state_n = S_DSAMP;
                end
            end
            S_DSAMP: begin
                tx_n = (phase == P_MARK) ? DUMP_MARK : i_dmp_data;
`ifdef HOST_BRIDGE_DUMP_CSUM_EN
                if (phase == P_CSUM) tx_n = csum;
`endif
                state_n = S_DSEND;
            end
            S_DCNT: begin
                // Scan stops at the first empty slot or after slot 31.
                cnt_n = cnt + {5'd0, i_dmp_valid};
                if (i_dmp_valid && o_dmp_fifo_pos != 5'd31) begin
                    pos_n = o_dmp_fifo_pos + 5'd1;
                end else begin
                    tx_n    = {2'b00, cnt_n};
                    state_n = S_DSEND;
                end
            end
            S_DSEND: begin
                if (i_tx_ready) begin
`ifdef HOST_BRIDGE_DUMP_CSUM_EN
                    tx_accept = 1'b1;
`endif
                    state_n = S_DADDR;
                    case (phase)
                        P_MARK: begin
                            phase_n = P_REG;
                            idx_n   = 6'd0;
                        end
                        P_REG: begin
                            if (idx == 6'd3) phase_n = P_CNT_IN;
                            else             idx_n   = idx + 6'd1;
                        end
                        P_CNT_IN: begin
                            if (cnt == 6'd0) phase_n = P_CNT_OUT;
                            else begin
                                phase_n = P_DAT_IN;
                                idx_n   = 6'd0;
                            end
                        end
                        P_DAT_IN: begin
                            if (idx + 6'd1 == cnt) phase_n = P_CNT_OUT;
                            else                   idx_n   = idx + 6'd1;
                        end
                        P_CNT_OUT: begin
                            if (cnt == 6'd0) frame_end = 1'b1;
                            else begin
                                phase_n = P_DAT_OUT;
                                idx_n   = 6'd0;
                            end
                        end
                        P_DAT_OUT: begin
                            if (idx + 6'd1 == cnt) frame_end = 1'b1;
                            else                   idx_n     = idx + 6'd1;
                        end
                        default: frame_end = 1'b1;
                    endcase
                    if (frame_end) begin
`ifdef HOST_BRIDGE_DUMP_CSUM_EN
                        if (phase != P_CSUM) phase_n   = P_CSUM;
                        else                 dump_done = 1'b1;
`else
                        dump_done = 1'b1;
`endif
                    end
                    if (dump_done) begin
                        state_n = S_IDLE;
                        sel_n   = SEL_PC;
                        pos_n   = 5'd0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_hrm_host_bridge.sv
// Self-checking bench for hrm_host_bridge: random RX/OUTBOX/dump traffic,
// expected TX and INBOX byte queues filled from a frame-level model.
module tb_hrm_host_bridge;
    localparam int         RX_DEPTH  = 4;
    localparam logic [7:0] DUMP_MARK = 8'hFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic [7:0] o_cpu_in_data;
    logic       o_cpu_in_wr;
    logic       i_cpu_in_full;
    logic [7:0] i_cpu_out_data;
    logic       i_cpu_out_empty;
    logic       o_cpu_out_rd;
    logic [2:0] o_dmp_chip_select;
    logic [4:0] o_dmp_fifo_pos;
    logic [7:0] i_dmp_data;
    logic       i_dmp_valid;
    logic       i_dump_req;
    logic       o_dump_busy;
    logic       o_rx_drop;

    hrm_host_bridge #(.RX_DEPTH(RX_DEPTH), .DUMP_MARK(DUMP_MARK)) dut (
        .clk(clk), .i_rst_n(rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_cpu_in_data(o_cpu_in_data), .o_cpu_in_wr(o_cpu_in_wr), .i_cpu_in_full(i_cpu_in_full),
        .i_cpu_out_data(i_cpu_out_data), .i_cpu_out_empty(i_cpu_out_empty), .o_cpu_out_rd(o_cpu_out_rd),
        .o_dmp_chip_select(o_dmp_chip_select), .o_dmp_fifo_pos(o_dmp_fifo_pos),
        .i_dmp_data(i_dmp_data), .i_dmp_valid(i_dmp_valid),
        .i_dump_req(i_dump_req), .o_dump_busy(o_dump_busy), .o_rx_drop(o_rx_drop)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_in_q[$];
    int tx_acc_cnt   = 0;
    int busy_acc_cnt = 0;
    int rd_cnt       = 0;
    int exp_rd_cnt   = 0;
    int ready_mode   = 0;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- CPU OUTBOX model ----------------
    logic [7:0] ob_mem [256];
    int ob_head = 0;
    int ob_tail = 0;
    assign i_cpu_out_empty = (ob_head == ob_tail);
    assign i_cpu_out_data  = ob_mem[ob_head[7:0]];

    // The OUTBOX advances just after the edge that sampled the read strobe.
    always @(negedge clk) begin
        if (rst_n && o_cpu_out_rd) begin
            @(posedge clk);
            #1;
            if (ob_head != ob_tail) ob_head = ob_head + 1;
        end
    end

    // ---------------- CPU dump port model ----------------
    // FIFO selects: 0 = INBOX, 1 = OUTBOX; registers at 2, 4, 5, 6.
    logic [7:0] snap_reg [4];
    logic [7:0] dmp_in   [32];
    logic [7:0] dmp_out  [32];
    int nin  = 0;
    int nout = 0;

    always_comb begin
        i_dmp_data  = 8'h00;
        i_dmp_valid = 1'b0;
        case (o_dmp_chip_select)
            3'd2: begin i_dmp_data = snap_reg[0]; i_dmp_valid = 1'b1; end
            3'd4: begin i_dmp_data = snap_reg[1]; i_dmp_valid = 1'b1; end
            3'd5: begin i_dmp_data = snap_reg[2]; i_dmp_valid = 1'b1; end
            3'd6: begin i_dmp_data = snap_reg[3]; i_dmp_valid = 1'b1; end
            3'd0: if (int'(o_dmp_fifo_pos) < nin) begin
                i_dmp_data = dmp_in[o_dmp_fifo_pos]; i_dmp_valid = 1'b1;
            end
            3'd1: if (int'(o_dmp_fifo_pos) < nout) begin
                i_dmp_data = dmp_out[o_dmp_fifo_pos]; i_dmp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Reference frame: mark, four registers, then each FIFO as count + bytes.
    function automatic int push_frame();
        logic [7:0] sum = 8'h00;
        int len = 1;
        exp_tx_q.push_back(DUMP_MARK);
        for (int i = 0; i < 4; i++) begin
            exp_tx_q.push_back(snap_reg[i]); sum += snap_reg[i]; len++;
        end
        exp_tx_q.push_back(8'(nin)); sum += 8'(nin); len++;
        for (int i = 0; i < nin; i++) begin
            exp_tx_q.push_back(dmp_in[i]); sum += dmp_in[i]; len++;
        end
        exp_tx_q.push_back(8'(nout)); sum += 8'(nout); len++;
        for (int i = 0; i < nout; i++) begin
            exp_tx_q.push_back(dmp_out[i]); sum += dmp_out[i]; len++;
        end
`ifdef HOST_BRIDGE_DUMP_CSUM_EN
        exp_tx_q.push_back(sum); len++;
`endif
        return len;
    endfunction

    // ---------------- TX ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       i_tx_ready = 1'b1;
            1:       i_tx_ready = 1'($urandom_range(0, 1));
            default: i_tx_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("tx_hold_valid", 32'(o_tx_valid), 32'd1);
                check("tx_hold_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (o_tx_valid && i_tx_ready) begin
                tx_acc_cnt++;
                if (o_dump_busy) busy_acc_cnt++;
                if (exp_tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected actual=%0h expected=none", o_tx_data);
                end else begin
                    check("tx_byte", 32'(o_tx_data), 32'(exp_tx_q.pop_front()));
                end
            end
            if (o_cpu_in_wr) begin
                check("in_wr_not_in_dump", 32'(prev_busy && o_dump_busy), 32'd0);
                if (exp_in_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL inbox_unexpected actual=%0h expected=none", o_cpu_in_data);
                end else begin
                    check("inbox_byte", 32'(o_cpu_in_data), 32'(exp_in_q.pop_front()));
                end
            end
            if (o_cpu_out_rd) rd_cnt++;
            prev_valid = o_tx_valid;
            prev_ready = i_tx_ready;
            prev_data  = o_tx_data;
            prev_busy  = o_dump_busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] d);
        i_rx_data  = d;
        i_rx_valid = 1'b1;
        tick(1);
        i_rx_valid = 1'b0;
    endtask

    task automatic load_outbox(input logic [7:0] d);
        ob_mem[ob_tail[7:0]] = d;
        ob_tail = ob_tail + 1;
        exp_tx_q.push_back(d);
        exp_rd_cnt++;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_tx_q.size() != 0 || exp_in_q.size() != 0 || ob_head != ob_tail ||
                o_dump_busy || o_tx_valid) && n < 4000) begin
            tick(1);
            n++;
        end
        tick(4);
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles expected=<4000 (tx_left=%0d in_left=%0d)",
                     name, n, exp_tx_q.size(), exp_in_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {3'd0, o_tx_valid, o_tx_data, o_cpu_in_wr, o_cpu_in_data, o_cpu_out_rd,
                     o_dmp_chip_select, o_dmp_fifo_pos, o_dump_busy, o_rx_drop},
              {3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 5'd0, 1'b0, 1'b0});
    endtask

    task automatic set_snapshot(input int n_in, input int n_out);
        for (int i = 0; i < 4; i++)  snap_reg[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) begin
            dmp_in[i]  = 8'($urandom);
            dmp_out[i] = 8'($urandom);
        end
        nin  = n_in;
        nout = n_out;
    endtask

    task automatic run_dump(input string name);
        int len;
        int base;
        len  = push_frame();
        base = busy_acc_cnt;
        i_dump_req = 1'b1;
        tick(1);
        i_dump_req = 1'b0;
        wait_idle(name);
        check({name, "_busy_bytes"}, 32'(busy_acc_cnt - base), 32'(len));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int len;
        int base;
        logic [7:0] d;

        rst_n = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        i_cpu_in_full = 1'b0; i_dump_req = 1'b0; i_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) snap_reg[i] = 8'h00;
        tick(3);
        check_reset_outputs("reset_init");
        rst_n = 1'b1;
        tick(2);

        // RX to INBOX, two bytes two cycles apart
        exp_in_q.push_back(8'h05);
        exp_in_q.push_back(8'h07);
        send_rx(8'h05);
        tick(1);
        send_rx(8'h07);
        wait_idle("rx_basic");
        check("rx_drop_clear", 32'(o_rx_drop), 32'd0);

        // Random RX bursts with a flickering full flag
        for (int b = 0; b < 15; b++) begin
            n = $urandom_range(1, RX_DEPTH);
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                exp_in_q.push_back(d);
                i_cpu_in_full = ($urandom_range(0, 2) == 0);
                send_rx(d);
                repeat ($urandom_range(0, 2)) begin
                    i_cpu_in_full = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
            i_cpu_in_full = 1'b0;
            wait_idle("rx_burst");
        end
        check("rx_drop_after_bursts", 32'(o_rx_drop), 32'd0);

        // Overflow: six bytes into a four-entry buffer while INBOX is full
        i_cpu_in_full = 1'b1;
        tick(1);
        for (int k = 0; k < 6; k++) begin
            d = 8'h10 + 8'(k);
            if (k < RX_DEPTH) exp_in_q.push_back(d);
            send_rx(d);
        end
        tick(1);
        check("rx_drop_set", 32'(o_rx_drop), 32'd1);
        i_cpu_in_full = 1'b0;
        wait_idle("rx_overflow");
        check("rx_drop_sticky", 32'(o_rx_drop), 32'd1);

        // OUTBOX drain with a toggling ready
        ready_mode = 1;
        load_outbox(8'hA1);
        load_outbox(8'hB2);
        wait_idle("outbox_ab");
        check("outbox_rd_count", 32'(rd_cnt), 32'(exp_rd_cnt));

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) load_outbox(8'($urandom));
            wait_idle("outbox_rand");
        end

        // Directed dump frame
        ready_mode = 0;
        snap_reg[0] = 8'h03; snap_reg[1] = 8'h2A; snap_reg[2] = 8'h10; snap_reg[3] = 8'h04;
        dmp_in[0] = 8'h01; dmp_in[1] = 8'h02;
        nin = 2; nout = 0;
        run_dump("dump_basic");

        // Random dumps, including empty and completely full FIFOs
        ready_mode = 1;
        set_snapshot(0, 32);   run_dump("dump_in0_out32");
        set_snapshot(32, 0);   run_dump("dump_in32_out0");
        set_snapshot($urandom_range(1, 31), $urandom_range(1, 31)); run_dump("dump_rand_a");
        set_snapshot($urandom_range(0, 32), $urandom_range(0, 32)); run_dump("dump_rand_b");

        // Long ready stall during a dump
        ready_mode = 2;
        set_snapshot(1, 1);
        len  = push_frame();
        i_dump_req = 1'b1; tick(1); i_dump_req = 1'b0;
        tick(25);
        ready_mode = 1;
        wait_idle("dump_stall");

        // Contention: dump request during OSEND, RX bytes during the dump
        ready_mode = 2;
        load_outbox(8'hC3);
        n = 0;
        while (!o_tx_valid && n < 50) begin tick(1); n++; end
        check("cont_osend_reached", 32'(o_tx_valid), 32'd1);
        set_snapshot(3, 2);
        base = busy_acc_cnt;
        len  = push_frame();
        i_dump_req = 1'b1; tick(1); i_dump_req = 1'b0;
        tick(3);
        ready_mode = 1;
        n = 0;
        while (!o_dump_busy && n < 50) begin tick(1); n++; end
        check("cont_busy_seen", 32'(o_dump_busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            exp_in_q.push_back(d);
            send_rx(d);
            tick(1);
        end
        wait_idle("contention");
        check("cont_busy_bytes", 32'(busy_acc_cnt - base), 32'(len));

        // Reset after the third dump byte
        ready_mode = 0;
        tick(2);
        set_snapshot(3, 2);
        len  = push_frame();
        base = tx_acc_cnt;
        i_dump_req = 1'b1; tick(1); i_dump_req = 1'b0;
        n = 0;
        while (tx_acc_cnt < base + 3 && n < 200) begin @(posedge clk); n++; end
        check("rst_third_byte", 32'(tx_acc_cnt - base), 32'd3);
        #1;
        rst_n = 1'b0;
        exp_tx_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid_dump");
        rst_n = 1'b1;
        tick(40);
        check("no_tx_after_reset", 32'(tx_acc_cnt - base), 32'd3);
        check("busy_after_reset", 32'(o_dump_busy), 32'd0);

        check("final_rd_count", 32'(rd_cnt), 32'(exp_rd_cnt));
        check("final_tx_left", 32'(exp_tx_q.size()), 32'd0);
        check("final_in_left", 32'(exp_in_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
